fifo_16_reader: RTL and testbench

FIFO_16_READER -- requirements
Module: fifo_16_reader

---
 rtl/fifo_16_reader.sv | 87 ++++++++
 tb/tb_fifo_16_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_16_reader.sv
// Read-side adapter for an upstream FIFO with one-cycle read latency: it issues reads and
// feeds a 2-entry in-order skid buffer that drives a valid/ready stream. It also counts transfers.
module fifo_16_reader #(
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [AWIDTH-1:0] fifo_dout,
    output logic [AWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       rd_count,
    output logic              ovf_err
);

    // Buffer level after this edge if nothing is dropped: occ + infl - pop (0..3).
    function automatic logic [2:0] commit_level(input logic [1:0] o, input logic i, input logic p);
        return {1'b0, o} + {2'b00, i} - {2'b00, p};
    endfunction

    function automatic logic [15:0] wrap_inc(input logic [15:0] c);
        return c + 16'd1;
    endfunction

    logic              run;
    logic              infl;
    logic [1:0]        occ;
    logic [AWIDTH-1:0] slot0_p1;
    logic [AWIDTH-1:0] slot1_p1;
    logic              pop;
    logic              capture;
    logic              drop;
    logic [2:0]        level;

    // run holds reads off until the first edge after reset is released.
    always_comb begin
        m_valid    = (occ != 2'd0);
        m_data     = slot0_p1;
        pop        = m_valid & m_ready;
        level      = commit_level(occ, infl, pop);
        fifo_rd_en = run & en & ~fifo_empty & (level < 3'd2);
        drop       = infl & (occ == 2'd2) & ~pop;
        capture    = infl & ~drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            infl     <= 1'b0;
            occ      <= 2'd0;
            rd_count <= 16'd0;
            ovf_err  <= 1'b0;
        end else begin
            run  <= 1'b1;
            infl <= fifo_rd_en;
            if (!drop) begin
                occ <= level[1:0];
            end
            if (pop) begin
                rd_count <= wrap_inc(rd_count);
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // slot0 is always the head; a pop shifts slot1 forward, and a capture fills the first free slot.
    always_ff @(posedge clk) begin
        if (pop) begin
            slot0_p1 <= (occ == 2'd2) ? slot1_p1 : fifo_dout;
            if (capture) begin
                slot1_p1 <= fifo_dout;
            end
        end else if (capture) begin
            if (occ == 2'd0) begin
                slot0_p1 <= fifo_dout;
            end else begin
                slot1_p1 <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_fifo_16_reader.sv
// Bench for fifo_16_reader: queue-based upstream FIFO and reference buffer model, a streaming
// vector table, hand-written corner sequences, and randomized traffic.
module tb_fifo_16_reader;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [AW-1:0] fifo_dout = '0;
    logic [AW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [15:0]   rd_count;
    logic          ovf_err;

    always #5 clk = ~clk;

    fifo_16_reader #(.AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count), .ovf_err(ovf_err)
    );

    int total = 0;
    int bad = 0;

    logic [AW-1:0] ufifo[$];
    logic [AW-1:0] mq[$];
    bit            pend_vld = 1'b0;
    logic [AW-1:0] pend = '0;
    bit            m_infl = 1'b0;
    logic [AW-1:0] m_infl_word = '0;
    logic [15:0]   m_count = '0;
    bit            m_ovf = 1'b0;
    bit            m_run = 1'b0;
    int            rd_pulses = 0;
    int            pops = 0;

    typedef struct {
        bit            en;
        bit            rdy;
        bit            e_rd;
        bit            e_vld;
        logic [AW-1:0] e_data;
        int            e_cnt;
    } vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check against the model, advance it.
    task automatic step(input bit r, input bit e, input bit rdy);
        bit            exp_vld;
        bit            p;
        bit            exp_rd;
        logic [AW-1:0] w;
        logic [AW-1:0] tmp;
        @(negedge clk);
        rst        = r;
        en         = e;
        m_ready    = rdy;
        fifo_empty = (ufifo.size() == 0);
        fifo_dout  = pend_vld ? pend : AW'($urandom);
        pend_vld   = 1'b0;
        #1;
        if (!r) begin
            mq.delete();
            m_infl  = 1'b0;
            m_count = '0;
            m_ovf   = 1'b0;
            m_run   = 1'b0;
        end
        exp_vld = (mq.size() != 0);
        p       = exp_vld & rdy;
        exp_rd  = m_run && e && (ufifo.size() != 0) && ((mq.size() + int'(m_infl) - int'(p)) < 2);
        chk("rd_en", fifo_rd_en, exp_rd);
        chk("m_valid", m_valid, exp_vld);
        if (exp_vld) chk("m_data", m_data, mq[0]);
        chk("rd_count", rd_count, m_count);
        chk("ovf_err", ovf_err, m_ovf);
        if (fifo_rd_en === 1'b1) rd_pulses++;
        if (m_valid === 1'b1 && rdy) pops++;
        w = (ufifo.size() != 0) ? ufifo[0] : '0;
        if (fifo_rd_en === 1'b1 && ufifo.size() != 0) begin
            pend     = ufifo.pop_front();
            pend_vld = 1'b1;
        end
        if (r) begin
            if (p) begin
                tmp = mq.pop_front();
                m_count++;
            end
            if (m_infl) begin
                if (mq.size() < 2) mq.push_back(m_infl_word);
                else m_ovf = 1'b1;
            end
            m_infl      = exp_rd;
            m_infl_word = w;
            m_run       = 1'b1;
        end
    endtask

    task automatic drain();
        ufifo.delete();
        repeat (4) step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) ufifo.push_back(AW'($urandom));
    endtask

    task automatic wait_next(input string name, input logic [AW-1:0] want);
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                step(1'b1, 1'b1, 1'b1);
                if (m_valid === 1'b1) begin
                    chk(name, m_data, want);
                    got = 1'b1;
                end
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [AW-1:0] first;
        logic [AW-1:0] nxt;
        bit            seen;

        for (int c = 0; c < 19; c++) begin
            vecs[c].en     = 1'b1;
            vecs[c].rdy    = 1'b1;
            vecs[c].e_rd   = (c <= 15);
            vecs[c].e_vld  = (c >= 2 && c <= 17);
            vecs[c].e_data = AW'(c - 1);
            vecs[c].e_cnt  = (c < 2) ? 0 : ((c - 2 > 16) ? 16 : c - 2);
        end

        // Reset state, with the FIFO non-empty and en high.
        step(1'b0, 1'b0, 1'b0);
        chk("rst_valid", m_valid, 0);
        chk("rst_count", rd_count, 0);
        for (int i = 1; i <= 16; i++) ufifo.push_back(AW'(i));
        step(1'b0, 1'b1, 1'b1);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_ovf", ovf_err, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("release_rd_en", fifo_rd_en, 0);

        // Streaming from cycle 0.
        for (int c = 0; c < 19; c++) begin
            step(1'b1, vecs[c].en, vecs[c].rdy);
            chk("vec_rd_en", fifo_rd_en, vecs[c].e_rd);
            chk("vec_valid", m_valid, vecs[c].e_vld);
            if (vecs[c].e_vld) chk("vec_data", m_data, vecs[c].e_data);
            chk("vec_count", rd_count, vecs[c].e_cnt);
        end
        chk("stream_count", rd_count, 16);
        drain();

        // Backpressure.
        load_rand(8);
        first = ufifo[0];
        rd_pulses = 0;
        repeat (10) step(1'b1, 1'b1, 1'b0);
        chk("bp_reads", rd_pulses, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, first);
        chk("bp_ovf", ovf_err, 0);
        repeat (12) step(1'b1, 1'b1, 1'b1);
        drain();

        // Reset with a full buffer.
        load_rand(6);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        nxt = ufifo[0];
        step(1'b0, 1'b1, 1'b0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_count", rd_count, 0);
        step(1'b1, 1'b1, 1'b1);
        wait_next("rst_full_next", nxt);
        drain();

        // Reset with a read in flight.
        load_rand(6);
        repeat (3) step(1'b1, 1'b1, 1'b1);
        nxt = ufifo[0];
        step(1'b0, 1'b1, 1'b1);
        chk("infl_rst_valid", m_valid, 0);
        step(1'b1, 1'b1, 1'b1);
        wait_next("rst_infl_next", nxt);
        drain();

        // Single-word FIFO.
        ufifo.push_back(AW'(9'h1a5));
        rd_pulses = 0;
        pops = 0;
        repeat (6) step(1'b1, 1'b1, 1'b1);
        chk("empty_reads", rd_pulses, 1);
        chk("empty_pops", pops, 1);
        chk("empty_rd_en", fifo_rd_en, 0);
        chk("empty_valid", m_valid, 0);
        drain();

        // en falls with a read in flight.
        load_rand(4);
        first = ufifo[0];
        rd_pulses = 0;
        seen = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b1);
            if (m_valid === 1'b1 && m_data === first) seen = 1'b1;
        end
        chk("endrop_reads", rd_pulses, 1);
        chk("endrop_seen", seen, 1);
        chk("endrop_left", ufifo.size(), 3);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && ufifo.size() < 6) ufifo.push_back(AW'($urandom));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        drain();

        // rd_count wrap after 65537 transfers.
        step(1'b0, 1'b0, 1'b0);
        pops = 0;
        for (int i = 0; i < 70000 && pops < 65537; i++) begin
            if (ufifo.size() < 4) load_rand(4);
            step(1'b1, 1'b1, 1'b1);
        end
        chk("wrap_pops", pops, 65537);
        step(1'b1, 1'b0, 1'b0);
        chk("wrap_count", rd_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
